// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-back path.
//   DW/AW/NREG : data width, register address width, register count
//   req_id_t   : write-back requester identity (ALU or load unit)
//   wb_req_t   : write-back payload (destination register + data)
package rf_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
//   clk, rst : clock, synchronous active-low reset
//   valid    : request vector, bit 0 = ALU, bit 1 = load unit
//   grant    : one-hot grant, combinational from valid and the pointer
module rf_rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_id_t last_q;

    // Tie goes to whichever requester was not granted last; no grants in reset.
    always_comb begin
        grant = 2'b00;
        if (rst) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_q == REQ_LD) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer moves only when something is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= REQ_LD;
        end else if (grant[0]) begin
            last_q <= REQ_ALU;
        end else if (grant[1]) begin
            last_q <= REQ_LD;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and busy scoreboard for the 32x32 register file.
// Arbitrates ALU and load results onto the single regfile write port through
// a one-stage output register, and tracks pending destinations for decode.
//   clk, rst                  : clock, synchronous active-low reset
//   alu_valid/ready/rd/data   : ALU result handshake
//   ld_valid/ready/rd/data    : load result handshake
//   iss_valid, iss_rd         : issuing instruction's destination (sets busy)
//   chk_rs1, chk_rs2          : decode sources checked for hazards
//   stall                     : combinational RAW/WAW hazard indication
//   rf_we, rf_a3, rf_wd       : registered regfile write port
//   busy                      : scoreboard vector, bit 0 always 0
//   wb_err                    : sticky flag, write-back to a non-busy register
module rf_wb_scheduler
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [DW-1:0]   ld_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [DW-1:0]   rf_wd,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    logic [1:0]      grant;
    logic            xfer;
    wb_req_t         alu_req;
    wb_req_t         ld_req;
    wb_req_t         sel_req;
    logic [NREG-1:0] busy_d;

    rf_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({ld_valid, alu_valid}),
        .grant (grant)
    );

    assign alu_ready = grant[0];
    assign ld_ready  = grant[1];
    assign xfer      = |grant;

    // Select the granted payload for the output stage.
    always_comb begin
        alu_req.rd   = alu_rd;
        alu_req.data = alu_data;
        ld_req.rd    = ld_rd;
        ld_req.data  = ld_data;
        sel_req      = grant[1] ? ld_req : alu_req;
    end

    // Output stage; rd == 0 transfers are consumed without a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= xfer && (sel_req.rd != '0);
            if (xfer) begin
                rf_a3 <= sel_req.rd;
                rf_wd <= sel_req.data;
            end
        end
    end

    // Scoreboard next state: clear on write-back, then set on issue so set wins.
    always_comb begin
        busy_d = busy;
        if (rf_we) begin
            busy_d[rf_a3] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_d;
            if (rf_we && !busy[rf_a3]) begin
                wb_err <= 1'b1;
            end
        end
    end

    // Hazard detect; the write-back cycle still reports busy (no write-through).
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            stall = (busy[chk_rs1] && (chk_rs1 != '0)) ||
                    (busy[chk_rs2] && (chk_rs2 != '0)) ||
                    (iss_valid && busy[iss_rd] && (iss_rd != '0));
        end
    end

endmodule
